universal_reg: RTL

- Parametrised multi-mode register; next generation of the lab's fixed-width D, T and JK flip-flops.
- Provides load, toggle, per-bit JK, shift, increment and decrement in one WIDTH-bit register, with carry and zero flags.
- Drives a shared data bus through a tri-state output enable.
- Serves as the general-purpose register and accumulator building block for the microcoded datapath.

---
 rtl/universal_reg_pkg.sv | 20 ++
 rtl/universal_reg_bus_driver.sv | 20 ++
 rtl/universal_reg.sv | 114 +++++++++++
 3 files changed

// File: rtl/universal_reg_pkg.sv
// -----------------------------------------------------------------------------
// universal_reg_pkg
// Shared constants for the universal register and its users, such as the
// microcode assembler tables. The package holds the operation select
// encodings and the width of the op field.
// -----------------------------------------------------------------------------
package universal_reg_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_TGL  = 3'b010;
    localparam logic [OP_W-1:0] OP_JK   = 3'b011;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b101;
    localparam logic [OP_W-1:0] OP_INC  = 3'b110;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b111;

endpackage

// File: rtl/universal_reg_bus_driver.sv
// -----------------------------------------------------------------------------
// bus_driver
// A WIDTH-generic tri-state buffer used by every master on the shared data bus.
//
// Ports:
//   in   input  WIDTH  value to place on the bus
//   oe   input  1      output enable; 0 releases the bus (all bits Z)
//   out  output WIDTH  tri-state bus connection
// -----------------------------------------------------------------------------
module bus_driver #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic             oe,
    output wire  [WIDTH-1:0] out
);

    assign out = oe ? in : {WIDTH{1'bz}};

endmodule

// File: rtl/universal_reg.sv
// -----------------------------------------------------------------------------
// universal_reg
// A multi-mode WIDTH-bit register. It supports hold, load, toggle, per-bit JK,
// shift left and right, increment and decrement. It provides a registered
// carry/borrow/shift-out flag, a combinational zero flag, and a tri-state copy
// of q for the shared data bus.
//
// Ports:
//   clock   input  1      rising-edge clock
//   reset   input  1      asynchronous, active-low reset
//   en      input  1      synchronous enable; 0 holds q and carry
//   op      input  OP_W   operation select (see universal_reg_pkg)
//   d       input  WIDTH  load data / T mask / J vector
//   k       input  WIDTH  K vector, used only by the JK operation
//   ser_in  input  1      serial input for shifts
//   oe      input  1      bus output enable
//   q       output WIDTH  register contents
//   bus     output WIDTH  tri-state copy of q
//   carry   output 1      carry / borrow / shift-out flag
//   zero    output 1      high when q is zero
// -----------------------------------------------------------------------------
module universal_reg
    import universal_reg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    input  logic             oe,
    output logic [WIDTH-1:0] q,
    output wire  [WIDTH-1:0] bus,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] q_next;
    logic             carry_next;
    logic [WIDTH:0]   inc_sum;

    // Keeping the increment one bit wider lets its top bit serve
    // directly as the carry out.
    assign inc_sum = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};

    // Next-state selection. Operations that leave the flag alone keep
    // carry_next at its default.
    always_comb begin
        q_next     = q;
        carry_next = carry;
        case (op)
            OP_HOLD: begin
                q_next = q;
            end
            OP_LOAD: begin
                q_next = d;
            end
            OP_TGL: begin
                q_next = q ^ d;
            end
            OP_JK: begin
                q_next = (d & ~q) | (~k & q);
            end
            OP_SHL: begin
                q_next     = {q[WIDTH-2:0], ser_in};
                carry_next = q[WIDTH-1];
            end
            OP_SHR: begin
                q_next     = {ser_in, q[WIDTH-1:1]};
                carry_next = q[0];
            end
            OP_INC: begin
                q_next     = inc_sum[WIDTH-1:0];
                carry_next = inc_sum[WIDTH];
            end
            OP_DEC: begin
                q_next     = q - {{(WIDTH-1){1'b0}}, 1'b1};
                carry_next = (q == '0);
            end
            default: begin
                q_next     = q;
                carry_next = carry;
            end
        endcase
    end

    // State register. Reset wins over everything, including an operation
    // on the same edge. The enable gates the whole update, so q and carry
    // always move together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q     <= RESET_VAL;
            carry <= 1'b0;
        end else if (en) begin
            q     <= q_next;
            carry <= carry_next;
        end
    end

    assign zero = (q == '0);

    bus_driver #(
        .WIDTH (WIDTH)
    ) u_bus_driver (
        .in  (q),
        .oe  (oe),
        .out (bus)
    );

endmodule
